shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter N, default 16: data width in bits, N >= 2.
REQ-002 SHALL have parameter SW, default $clog2(N): width of the shift-amount port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port clr_n, input, 1 bit: synchronous clear, active-low.
REQ-006 SHALL have port set_n, input, 1 bit: synchronous set, active-low.
REQ-007 SHALL have port start, input, 1 bit: request a new operation.
REQ-008 SHALL have port op, input, 3 bits: operation code.
REQ-009 SHALL have port amount, input, SW bits: shift count.
REQ-010 SHALL have ports Ls and Rs, input, 1 bit each: fill bits for left and right logical shifts.
REQ-011 SHALL have port reg_in, input, N bits: parallel load data.
REQ-012 SHALL have port reg_out, output, N bits: register contents.
REQ-013 SHALL have port carry, output, 1 bit: last bit shifted or rotated out.
REQ-014 SHALL have port busy, output, 1 bit: operation in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL decode op as:
- 000 hold; 001 load; 010 SLL (fill Ls); 011 SRL (fill Rs);
- 100 SRA (fill with the MSB); 101 ROL; 110 ROR;
- 111 reserved, treated as hold.
REQ-017 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-018 SHALL accept start only in IDLE, capturing op, amount, Ls and Rs at that edge; start in SHIFT or DONE is ignored.
REQ-019 SHALL, on an accepted hold or load, update reg_out at the accept edge (load: reg_in, carry cleared to 0) and go to DONE.
REQ-020 SHALL, on an accepted shift or rotate with amount > 0, go to SHIFT with the counter loaded to amount; reg_out is unchanged at the accept edge.
REQ-021 SHALL, in SHIFT, perform exactly one 1-bit step per cycle, set carry to the bit leaving the register, and decrement the counter.
REQ-022 SHALL go from SHIFT to DONE on the edge performing the final step, so reg_out is final in the first DONE cycle.
REQ-023 SHALL give an accepted shift a latency of amount+1 edges from accept to done high.
REQ-024 SHALL, for a shift or rotate with amount = 0, go straight to DONE with reg_out and carry unchanged.
REQ-025 SHALL drive busy = 1 exactly in SHIFT and done = 1 exactly in DONE; DONE always returns to IDLE after one cycle.
REQ-026 SHALL allow amount up to N-1; rotate by k matches a full rotate by k mod N, and SLL/SRL by N-1 leaves one original bit.
REQ-027 SHALL, when clr_n = 0 on any edge: set reg_out = 0, carry = 0, state IDLE, no done pulse, aborting any operation.
REQ-028 SHALL, when set_n = 0 with clr_n = 1: set reg_out all ones, carry = 0, state IDLE, aborting any operation.
REQ-029 SHALL apply priority rst > clr_n > set_n > state machine.

Reset
REQ-030 SHALL, while rst = 1, immediately force reg_out = 0, carry = 0, busy = 0, done = 0, state IDLE and counter 0, regardless of clk.
REQ-031 SHALL, when rst is asserted mid-shift, abandon the operation; the first start after release begins a fresh operation.

Structure
REQ-032 SHALL take op codes and the state encoding from a shared package shift_pkg.
REQ-033 SHALL implement the one-bit step as combinational sub-module shift_step (inputs: value, op, Ls, Rs; outputs: next value, out bit).
REQ-034 SHALL instantiate shift_step once.

Verification
REQ-035 SHALL cover: N=8, load 0xB4, then SLL amount 3 with Ls=1 -> reg_out 0xA7, carry 1, done 4 edges after accept.
REQ-036 SHALL cover: N=8, load 0x81, then SRA amount 2 -> reg_out 0xE0, carry 0; ROR amount 1 on 0x81 -> 0xC0, carry 1.
REQ-037 SHALL cover: start pulsed again while busy -> ignored; result and done timing unchanged.
REQ-038 SHALL cover: clr_n low mid-SHIFT -> reg_out 0 next edge, busy 0, no done; rst pulse mid-SHIFT -> immediate zeros.
REQ-039 SHALL cover: amount 0 ROL -> done one edge after accept, reg_out and carry unchanged.
REQ-040 SHALL cover: N=16, rotate-left amount 15 on 0x0001 -> 0x8000, carry 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit.
// Holds the operation codes and the controller state encoding so the top level
// and the one-bit step datapath decode op identically.
package shift_pkg;

  typedef enum logic [2:0] {
    OpHold = 3'b000,
    OpLoad = 3'b001,
    OpSll  = 3'b010,
    OpSrl  = 3'b011,
    OpSra  = 3'b100,
    OpRol  = 3'b101,
    OpRor  = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // True for the ops that walk the register one bit per cycle.
  function automatic logic is_shift_op(op_e op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra) ||
           (op == OpRol) || (op == OpRor);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step (purely combinational).
// Ports:
//   value      - current register contents
//   op         - operation (shift_pkg::op_e)
//   Ls, Rs     - fill bits for logical left / right shifts
//   next_value - contents after one step
//   out_bit    - bit leaving the register on this step (0 for non-shift ops)
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] value,
  input  op_e          op,
  input  logic         Ls,
  input  logic         Rs,
  output logic [N-1:0] next_value,
  output logic         out_bit
);

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      OpSll: begin
        next_value = {value[N-2:0], Ls};
        out_bit    = value[N-1];
      end
      OpSrl: begin
        next_value = {Rs, value[N-1:1]};
        out_bit    = value[0];
      end
      OpSra: begin
        next_value = {value[N-1], value[N-1:1]};
        out_bit    = value[0];
      end
      OpRol: begin
        next_value = {value[N-2:0], value[N-1]};
        out_bit    = value[N-1];
      end
      OpRor: begin
        next_value = {value[0], value[N-1:1]};
        out_bit    = value[0];
      end
      default: begin
        next_value = value;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate register.
// A start in IDLE captures op/amount/fills; hold and load finish at the accept
// edge, shifts and rotates step one bit per cycle in SHIFT, then DONE pulses
// for one cycle.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clr_n, set_n  - synchronous clear / set (clear wins), both abort operations
//   start, op     - operation request and code
//   amount        - shift count (0 .. N-1)
//   Ls, Rs        - fill bits for SLL / SRL
//   reg_in        - parallel load data
//   reg_out       - register contents
//   carry         - last bit shifted or rotated out
//   busy, done    - high in SHIFT / high for the single DONE cycle
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_n,
  input  logic          set_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [SW-1:0] amount,
  input  logic          Ls,
  input  logic          Rs,
  input  logic [N-1:0]  reg_in,
  output logic [N-1:0]  reg_out,
  output logic          carry,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [N-1:0]  val_q, val_d;
  logic          carry_q, carry_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          ls_q, ls_d;
  logic          rs_q, rs_d;

  logic [N-1:0]  step_val;
  logic          step_bit;
  op_e           op_in;

  assign op_in = op_e'(op);

  shift_step #(
    .N(N)
  ) u_step (
    .value      (val_q),
    .op         (op_q),
    .Ls         (ls_q),
    .Rs         (rs_q),
    .next_value (step_val),
    .out_bit    (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ls_d    = ls_q;
    rs_d    = rs_q;

    if (!clr_n) begin
      val_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = StIdle;
    end else if (!set_n) begin
      val_d   = '1;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_d  = op_in;
            ls_d  = Ls;
            rs_d  = Rs;
            cnt_d = amount;
            if (op_in == OpLoad) begin
              val_d   = reg_in;
              carry_d = 1'b0;
              state_d = StDone;
            end else if (is_shift_op(op_in) && (amount != '0)) begin
              state_d = StShift;
            end else begin
              // Hold, reserved, or a zero-length shift: nothing to do.
              state_d = StDone;
            end
          end
        end
        StShift: begin
          val_d   = step_val;
          carry_d = step_bit;
          cnt_d   = cnt_q - SW'(1);
          // Leave on the edge that performs the last step so reg_out is
          // already final in the DONE cycle.
          if (cnt_q == SW'(1)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpHold;
      val_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ls_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
    end
  end

  assign reg_out = val_q;
  assign carry   = carry_q;
  assign busy    = (state_q == StShift);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: an 8-bit and a 16-bit instance share the
// control buses; each has its own start. Expected results are computed with
// plain arithmetic and queued at accept time; a monitor checks them on done.
module tb_shift_unit;

  logic        clk;
  logic        rst;
  logic        clr_n;
  logic        set_n;
  logic [1:0]  start;
  logic [2:0]  op;
  logic [3:0]  amount;
  logic        ls;
  logic        rs;
  logic [15:0] reg_in;

  logic [7:0]  ro0;
  logic [15:0] ro1;
  logic [1:0]  carry;
  logic [1:0]  busy;
  logic [1:0]  done;

  shift_unit #(
    .N(8)
  ) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .clr_n   (clr_n),
    .set_n   (set_n),
    .start   (start[0]),
    .op      (op),
    .amount  (amount[2:0]),
    .Ls      (ls),
    .Rs      (rs),
    .reg_in  (reg_in[7:0]),
    .reg_out (ro0),
    .carry   (carry[0]),
    .busy    (busy[0]),
    .done    (done[0])
  );

  shift_unit #(
    .N(16)
  ) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .clr_n   (clr_n),
    .set_n   (set_n),
    .start   (start[1]),
    .op      (op),
    .amount  (amount),
    .Ls      (ls),
    .Rs      (rs),
    .reg_in  (reg_in),
    .reg_out (ro1),
    .carry   (carry[1]),
    .busy    (busy[1]),
    .done    (done[1])
  );

  typedef struct {
    int          dut;
    logic [15:0] val;
    logic        c;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          mon_idx;
  logic [15:0] mval[2];
  logic        mcar[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] out_of(input int d);
    return (d == 1) ? ro1 : {8'h00, ro0};
  endfunction

  // Whole-operation reference: result of shifting by amt at once.
  function automatic void model_op(input int n, input logic [2:0] o, input int amt,
                                   input logic l, input logic r, input logic [15:0] din,
                                   inout logic [15:0] val, inout logic c);
    logic [31:0] v, mask, top;
    v    = {16'h0, val};
    mask = (32'd1 << n) - 32'd1;
    top  = mask & ~(mask >> amt);
    if (o == 3'd1) begin
      v = {16'h0, din} & mask;
      c = 1'b0;
    end else if (o >= 3'd2 && o <= 3'd6 && amt > 0) begin
      case (o)
        3'd2: begin c = v[n-amt]; v = ((v << amt) | (l ? ((32'd1 << amt) - 1) : 0)) & mask; end
        3'd3: begin c = v[amt-1]; v = (v >> amt) | (r ? top : 32'd0); end
        3'd4: begin c = v[amt-1]; v = (v >> amt) | (v[n-1] ? top : 32'd0); end
        3'd5: begin v = ((v << amt) | (v >> (n - amt))) & mask; c = v[0]; end
        default: begin v = ((v >> amt) | (v << (n - amt))) & mask; c = v[n-1]; end
      endcase
    end
    val = v[15:0];
  endfunction

  // Drive one request; when push is set the DUT is known idle and the
  // expected response is queued. The accept edge is counted as the first edge.
  task automatic issue(input int d, input logic [2:0] o, input int amt, input logic l,
                       input logic r, input logic [15:0] din, input bit push);
    exp_t e;
    int   eff;
    @(negedge clk);
    start[d] = 1'b1;
    op       = o;
    amount   = amt[3:0];
    ls       = l;
    rs       = r;
    reg_in   = din;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    if (push) begin
      eff = (o >= 3'd2 && o <= 3'd6) ? amt : 0;
      model_op((d == 1) ? 16 : 8, o, amt, l, r, din, mval[d], mcar[d]);
      e.dut = d;
      e.val = mval[d];
      e.c   = mcar[d];
      e.due = cyc + eff;
      sb.push_back(e);
      if (eff > 0) chk("busy_after_accept", {31'h0, busy[d]}, 32'd1);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest pending entry for its DUT.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          mon_idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == d && mon_idx < 0) mon_idx = i;
          end
          if (mon_idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: dut %0d got done=1 expected done=0", d);
          end else begin
            chk("reg_out", {16'h0, out_of(d)}, {16'h0, sb[mon_idx].val});
            chk("carry", {31'h0, carry[d]}, {31'h0, sb[mon_idx].c});
            chk("done_cycle", cyc, sb[mon_idx].due);
            chk("busy_at_done", {31'h0, busy[d]}, 32'd0);
            sb.delete(mon_idx);
          end
        end
      end
    end
  end

  initial begin
    int d, n;
    rst    = 1'b1;
    clr_n  = 1'b1;
    set_n  = 1'b1;
    start  = 2'b00;
    op     = 3'd0;
    amount = 4'd0;
    ls     = 1'b0;
    rs     = 1'b0;
    reg_in = 16'h0;
    mval[0] = 16'h0; mval[1] = 16'h0;
    mcar[0] = 1'b0;  mcar[1] = 1'b0;
    #3;
    chk("reset_reg_out8", {24'h0, ro0}, 32'h0);
    chk("reset_reg_out16", {16'h0, ro1}, 32'h0);
    chk("reset_flags", {26'h0, carry, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load then SLL 3 with fill 1: 0xB4 -> 0xA7, carry 1.
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h00B4, 1'b1); drain();
    issue(0, 3'd2, 3, 1'b1, 1'b0, 16'h0000, 1'b1); drain();
    chk("sll3_value", {24'h0, ro0}, 32'hA7);

    // SRA 2 on 0x81 -> 0xE0, carry 0; ROR 1 on 0x81 -> 0xC0, carry 1.
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h0081, 1'b1); drain();
    issue(0, 3'd4, 2, 1'b0, 1'b0, 16'h0000, 1'b1); drain();
    chk("sra2_value", {24'h0, ro0}, 32'hE0);
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h0081, 1'b1); drain();
    issue(0, 3'd6, 1, 1'b0, 1'b0, 16'h0000, 1'b1); drain();
    chk("ror1_value", {24'h0, ro0}, 32'hC0);

    // Zero-length rotate: done right after accept, value and carry kept.
    issue(0, 3'd5, 0, 1'b0, 1'b0, 16'h0000, 1'b1); drain();
    chk("rol0_carry", {31'h0, carry[0]}, 32'd1);

    // Start while busy is ignored.
    issue(0, 3'd2, 5, 1'b0, 1'b0, 16'h0000, 1'b1);
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h0055, 1'b0);
    drain();

    // Clear mid-shift: zeros at the next edge, no done.
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h00F0, 1'b1); drain();
    issue(0, 3'd3, 6, 1'b0, 1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    sb.delete();
    clr_n = 1'b0;
    mval[0] = 16'h0; mval[1] = 16'h0; mcar[0] = 1'b0; mcar[1] = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk("clr_reg_out", {24'h0, ro0}, 32'h0);
    chk("clr_flags", {29'h0, carry[0], busy[0], done[0]}, 32'h0);
    repeat (8) @(negedge clk);

    // Set: all ones, carry 0.
    set_n = 1'b0;
    mval[0] = 16'h00FF; mval[1] = 16'hFFFF; mcar[0] = 1'b0; mcar[1] = 1'b0;
    @(negedge clk);
    set_n = 1'b1;
    chk("set_reg_out8", {24'h0, ro0}, 32'hFF);
    chk("set_reg_out16", {16'h0, ro1}, 32'hFFFF);

    // Asynchronous reset mid-shift: immediate zeros, then a fresh operation.
    issue(0, 3'd5, 7, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    sb.delete();
    #2;
    rst = 1'b1;
    mval[0] = 16'h0; mval[1] = 16'h0; mcar[0] = 1'b0; mcar[1] = 1'b0;
    #1;
    chk("rst_reg_out", {24'h0, ro0}, 32'h0);
    chk("rst_flags", {29'h0, carry[0], busy[0], done[0]}, 32'h0);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(0, 3'd1, 0, 1'b0, 1'b0, 16'h005A, 1'b1); drain();
    issue(0, 3'd3, 4, 1'b0, 1'b1, 16'h0000, 1'b1); drain();

    // 16-bit: rotate left 15 on 0x0001 -> 0x8000, carry 0.
    issue(1, 3'd1, 0, 1'b0, 1'b0, 16'h0001, 1'b1); drain();
    issue(1, 3'd5, 15, 1'b0, 1'b0, 16'h0000, 1'b1); drain();
    chk("rol15_value", {16'h0, ro1}, 32'h8000);

    // Random operations on both widths.
    for (int t = 0; t < 200; t++) begin
      d = ($urandom_range(0, 3) == 0) ? 1 : 0;
      n = (d == 1) ? 16 : 8;
      issue(d, 3'($urandom_range(0, 7)), $urandom_range(0, n - 1), 1'($urandom),
            1'($urandom), 16'($urandom), 1'b1);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
